// File: rtl/prefix_adder_pkg.sv
// Shared constants for the pipelined Kogge-Stone adder.
//   OP_ADD / OP_SUB : encoding of the op input
//   level_span()    : distance between the two inputs of a black cell at prefix level k
package prefix_adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Level k (1-based) combines bit j with bit j - 2^(k-1).
  function automatic int level_span(input int level);
    return 1 << (level - 1);
  endfunction

endpackage

// File: rtl/pipelined_prefix_adder_if.sv
// Operand/result handshake bundle for pipelined_prefix_adder.
//   master : drives operands (in_valid, x, y, c_in, op) and out_ready
//   slave  : the adder; drives in_ready and the result beat (out_valid, sum, c_out, ovf)
interface pipelined_prefix_adder_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             c_in;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, x, y, c_in, op, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, x, y, c_in, op, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );

endinterface

// File: rtl/prefix_node.sv
// Kogge-Stone black cell: merges a high group (gh, ph) with the adjacent low group (gl, pl).
//   g = gh | ph & gl,  p = ph & pl
module prefix_node (
  input  logic gh,
  input  logic ph,
  input  logic gl,
  input  logic pl,
  output logic g,
  output logic p
);

  assign g = gh | (ph & gl);
  assign p = ph & pl;

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of pipelined_prefix_adder_if (operands in, result out)
// Pipeline: stage 0 (gen/prop), stages 1..LEVELS (one prefix level each),
// output stage (sum/c_out/ovf). Latency LEVELS+2 cycles, one beat per cycle.
module pipelined_prefix_adder
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LEVELS = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipelined_prefix_adder_if.slave bus
);

  localparam int LAST = LEVELS + 1;

  logic [LAST:0]    vld_q;
  logic [LAST:0]    adv;
  logic             accept;

  logic [WIDTH-1:0] g_q    [0:LEVELS];
  logic [WIDTH-1:0] p_q    [0:LEVELS];
  logic [WIDTH-1:0] prop_q [0:LEVELS];
  logic             cin_q  [0:LEVELS];

  logic [WIDTH-1:0] g_nx [1:LEVELS];
  logic [WIDTH-1:0] p_nx [1:LEVELS];

  logic [WIDTH-1:0] y_eff;
  logic [WIDTH-1:0] gen0;
  logic [WIDTH-1:0] prop0;
  logic             cin0;

  logic [WIDTH-1:0] carries;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  // A stage may advance when any stage from it to the output has a hole,
  // or the output is being drained; walking from the output down gives
  // the "successor empty or advancing" chain without a combinational loop.
  always_comb begin : advance_chain
    logic room;
    adv  = '0;
    room = bus.out_ready;
    for (int k = LAST; k >= 0; k--) begin
      room   = room | ~vld_q[k];
      adv[k] = room;
    end
  end

  assign bus.in_ready = rst_n & adv[0];
  assign accept       = bus.in_valid & bus.in_ready;

  // The carry-in is the generate of a virtual bit -1 (its propagate is 0),
  // so merging it into bit 0 here lets LEVELS levels cover all WIDTH bits.
  always_comb begin
    y_eff   = (bus.op == OP_ADD) ? bus.y : ~bus.y;
    cin0    = (bus.op == OP_SUB) ? 1'b1 : bus.c_in;
    prop0   = bus.x ^ y_eff;
    gen0    = bus.x & y_eff;
    gen0[0] = gen0[0] | (prop0[0] & cin0);
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    localparam int SPAN = level_span(k);
    for (genvar j = 0; j < WIDTH; j++) begin : g_bit
      if (j >= SPAN) begin : g_node
        prefix_node u_node (
          .gh (g_q[k-1][j]),
          .ph (p_q[k-1][j]),
          .gl (g_q[k-1][j-SPAN]),
          .pl (p_q[k-1][j-SPAN]),
          .g  (g_nx[k][j]),
          .p  (p_nx[k][j])
        );
      end else begin : g_pass
        assign g_nx[k][j] = g_q[k-1][j];
        assign p_nx[k][j] = p_q[k-1][j];
      end
    end
  end

  // Datapath registers carry no reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (adv[0]) begin
      g_q[0]    <= gen0;
      p_q[0]    <= prop0;
      prop_q[0] <= prop0;
      cin_q[0]  <= cin0;
    end
    for (int k = 1; k <= LEVELS; k++) begin
      if (adv[k]) begin
        g_q[k]    <= g_nx[k];
        p_q[k]    <= p_nx[k];
        prop_q[k] <= prop_q[k-1];
        cin_q[k]  <= cin_q[k-1];
      end
    end
  end

  // After the last level g_q[LEVELS][i] is the carry out of bit i.
  assign carries = {g_q[LEVELS][WIDTH-2:0], cin_q[LEVELS]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (adv[0]) begin
        vld_q[0] <= accept;
      end
      for (int k = 1; k <= LAST; k++) begin
        if (adv[k]) begin
          vld_q[k] <= vld_q[k-1];
        end
      end
      if (adv[LAST] && vld_q[LEVELS]) begin
        sum_q  <= prop_q[LEVELS] ^ carries;
        cout_q <= g_q[LEVELS][WIDTH-1];
        ovf_q  <= carries[WIDTH-1] ^ g_q[LEVELS][WIDTH-1];
      end
    end
  end

  assign bus.out_valid = vld_q[LAST];
  assign bus.sum       = sum_q;
  assign bus.c_out     = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Self-checking bench for pipelined_prefix_adder (WIDTH=8): directed corner
// cases, a stalled stream, reset with beats in flight, and a random run
// scored against an integer-arithmetic reference model.
module tb_pipelined_prefix_adder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pipelined_prefix_adder_if #(.WIDTH(8)) bus ();

  pipelined_prefix_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       v;
    int         acc;
    bit         exact;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    bit         ci;
    bit         o;
    logic [7:0] s;
    bit         c;
    bit         v;
  } dir_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   prev_stall = 0;
  logic [7:0] prev_sum;
  logic prev_c, prev_v;
  bit   saw_block;
  logic [7:0] obs_s;
  logic obs_c, obs_v;

  dir_t dirs [5] = '{
    '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
    '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1},
    '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0},
    '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0},
    '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1}
  };

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned/signed integer arithmetic.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input bit ci, input bit o);
    exp_t e;
    int ua, ub, sa, sb, r, sr;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    if (!o) begin
      r   = ua + ub + ci;
      sr  = sa + sb + ci;
      e.c = (r > 255);
    end else begin
      r   = ua - ub;
      sr  = sa - sb;
      e.c = (ua >= ub);
    end
    e.s     = r[7:0];
    e.v     = (sr > 127) || (sr < -128);
    e.acc   = 0;
    e.exact = 0;
    return e;
  endfunction

  // One clock cycle, entered and left at the falling edge.
  task automatic cycle(input bit iv, input logic [7:0] xx, input logic [7:0] yy,
                       input bit ci, input bit o, input bit ordy, input bit exact,
                       output bit accepted);
    exp_t e;
    bus.in_valid  = iv;
    bus.x         = xx;
    bus.y         = yy;
    bus.c_in      = ci;
    bus.op        = o;
    bus.out_ready = ordy;
    #1;
    if (prev_stall) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_result", {bus.ovf, bus.c_out, bus.sum}, {prev_v, prev_c, prev_sum});
    end
    if (!bus.in_ready) saw_block = 1;
    accepted = iv && bus.in_ready;
    if (bus.out_valid && ordy) begin
      if (q.size() == 0) begin
        check("stale_beat", bus.out_valid, 0);
      end else begin
        e = q.pop_front();
        obs_s = bus.sum;
        obs_c = bus.c_out;
        obs_v = bus.ovf;
        check("sum", bus.sum, e.s);
        check("c_out", bus.c_out, e.c);
        check("ovf", bus.ovf, e.v);
        if (e.exact) check("latency", cyc - e.acc, 5);
      end
    end
    if (accepted) begin
      e       = model(xx, yy, ci, o);
      e.acc   = cyc;
      e.exact = exact;
      q.push_back(e);
    end
    prev_stall = bus.out_valid && !ordy;
    prev_sum   = bus.sum;
    prev_c     = bus.c_out;
    prev_v     = bus.ovf;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    bit a;
    n = 0;
    while (q.size() > 0 && n < 60) begin
      cycle(0, 8'h00, 8'h00, 0, 0, 1, 0, a);
      n++;
    end
    check("drain_timeout", q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_sum"}, bus.sum, 0);
    check({tag, "_c_out"}, bus.c_out, 0);
    check({tag, "_ovf"}, bus.ovf, 0);
  endtask

  initial begin
    bit a;
    int sent, budget;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    bus.c_in      = 1'b0;
    bus.op        = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    #1;
    check("first_in_ready", bus.in_ready, 1);
    @(negedge clk);

    // Directed corner cases, each alone in the pipe with exact latency.
    foreach (dirs[i]) begin
      cycle(1, dirs[i].a, dirs[i].b, dirs[i].ci, dirs[i].o, 1, 1, a);
      check("dir_accept", a, 1);
      drain();
      check("dir_sum", obs_s, dirs[i].s);
      check("dir_c_out", obs_c, dirs[i].c);
      check("dir_ovf", obs_v, dirs[i].v);
    end

    // Back-to-back beats with out_ready high: one accepted every cycle.
    for (int i = 0; i < 8; i++) begin
      cycle(1, 8'($urandom()), 8'($urandom()), 1'($urandom()), 1'($urandom()), 1, 1, a);
      check("throughput_accept", a, 1);
    end
    drain();

    // Ten-beat stream with the output stalled on cycles 3..6.
    saw_block = 0;
    sent      = 0;
    for (int t = 0; t < 40 && sent < 10; t++) begin
      cycle(1, 8'($urandom()), 8'($urandom()), 1'($urandom()), 1'($urandom()),
            !(t >= 3 && t <= 6), 0, a);
      if (a) sent++;
    end
    check("stream_sent", sent, 10);
    check("stream_backpressure", saw_block, 1);
    drain();

    // Reset with three beats in flight, the oldest already at the output.
    for (int i = 0; i < 3; i++)
      cycle(1, 8'($urandom()), 8'($urandom()), 1'($urandom()), 1'($urandom()), 1, 0, a);
    cycle(0, 8'h00, 8'h00, 0, 0, 0, 0, a);
    cycle(0, 8'h00, 8'h00, 0, 0, 0, 0, a);
    check("pre_reset_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    q.delete();
    prev_stall   = 0;
    bus.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("held_reset");
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check("post_reset_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 10; i++) cycle(0, 8'h00, 8'h00, 0, 0, 1, 0, a);
    cycle(1, 8'h3C, 8'h5A, 1, 0, 1, 1, a);
    check("post_reset_accept", a, 1);
    drain();
    check("post_reset_sum", obs_s, 8'h97);

    // Random operands, random valid and ready.
    sent   = 0;
    budget = 0;
    while (sent < 10000 && budget < 60000) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom()), 8'($urandom()),
            1'($urandom()), 1'($urandom()), $urandom_range(0, 3) != 0, 0, a);
      if (a) sent++;
      budget++;
    end
    check("random_sent", sent, 10000);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
